collision_detector: RTL

//   Reads the rendered pixel stream (dinosaur and cactus layers) during the visible scan.

---
 rtl/collision_detector.sv | 109 ++++++++++
 1 files changed

// File: rtl/collision_detector.sv
// Per-frame dinosaur/cactus overlap detector with a game_over request/acknowledge
// handshake and a saturating count of frames survived.
module collision_detector #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned HIT_THRESHOLD = 4,
  parameter int unsigned GRACE_FRAMES  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        pix_en,
  input  logic        vs,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        px_dinosaur,
  input  logic        px_cactus,
  input  logic        game_status,
  input  logic        hit_ack,
  output logic        game_over,
  output logic        frame_tick,
  output logic [15:0] frames,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;

  logic [1:0]  state;
  logic [9:0]  ovl_cnt;
  logic [3:0]  grace_cnt;
  logic        vs_d;
  logic        gs_d;
  logic        frame_end;
  logic        arm;
  logic        overlap;
  logic [15:0] frames_inc;

  assign frame_end  = vs_d & ~vs;
  assign arm        = ~gs_d & game_status;
  assign overlap    = (state == S_ARMED) & pix_en
                    & (32'(row_addr) < V_ACTIVE) & (32'(col_addr) < H_ACTIVE)
                    & px_dinosaur & px_cactus;
  assign frames_inc = (frames != '1) ? frames + 16'd1 : frames;
  assign state_dbg  = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      game_over  <= 1'b0;
      frame_tick <= 1'b0;
      frames     <= '0;
      ovl_cnt    <= '0;
      grace_cnt  <= '0;
      vs_d       <= 1'b1;
      gs_d       <= 1'b0;
    end else begin
      vs_d       <= vs;
      gs_d       <= game_status;
      frame_tick <= frame_end;

      // Frame end clears the counter and drops any same-cycle increment;
      // the FSM below may also clear it, and its later assignment wins.
      if (frame_end)
        ovl_cnt <= '0;
      else if (overlap && ovl_cnt != '1)
        ovl_cnt <= ovl_cnt + 10'd1;

      case (state)
        S_IDLE: begin
          if (arm) begin
            state     <= S_ARMED;
            frames    <= '0;
            ovl_cnt   <= '0;
            grace_cnt <= 4'(GRACE_FRAMES);
          end
        end
        S_ARMED: begin
          // Losing game_status takes priority over a coincident frame end.
          if (!game_status) begin
            state   <= S_IDLE;
            ovl_cnt <= '0;
          end else if (frame_end) begin
            if (grace_cnt != '0) begin
              grace_cnt <= grace_cnt - 4'd1;
              frames    <= frames_inc;
            end else if (ovl_cnt >= 10'(HIT_THRESHOLD)) begin
              state     <= S_HIT;
              game_over <= 1'b1;
            end else begin
              frames <= frames_inc;
            end
          end
        end
        S_HIT: begin
          if (hit_ack) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
